// File: rtl/mem_io_pkg.sv
// Shared decode constants for mem_io_ctrl: region nibbles, MMIO offsets,
// access-size encodings and STATUS bit positions.
package mem_io_pkg;

    localparam logic [3:0] REGION_RAM  = 4'h0;
    localparam logic [3:0] REGION_MMIO = 4'hF;

    // MMIO offsets expressed as word indices (addr[7:2])
    localparam logic [5:0] OFF_LED    = 6'd0;
    localparam logic [5:0] OFF_SW     = 6'd1;
    localparam logic [5:0] OFF_CYCLE  = 6'd2;
    localparam logic [5:0] OFF_UART   = 6'd3;
    localparam logic [5:0] OFF_STATUS = 6'd4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_e;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_MISAL = 2;
    localparam int ST_UNMAP = 3;

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return a[0];
            SZ_WORD: return a != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered head; no combinational bypass from push to head.
// A push while full is accepted only if a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [PW:0]      cnt_q;
    logic             do_push, do_pop;

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // DEPTH is a power of two, so the count MSB alone means full
    assign full_o  = cnt_q[PW];
    assign empty_o = cnt_q == '0;
    assign rdata_o = mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/mem_io_ctrl.sv
// Load/store port decoder: data RAM, MMIO registers, cycle counter, UART TX queue.
// Define MEM_IO_UART_EN to build the transmit FIFO; otherwise the UART ports are tied off.
module mem_io_ctrl #(
    parameter int RAM_WORDS  = 4096,
    parameter int UART_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [2:0]  mem_u_b_h_w,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] mem_rdata,
    input  logic [15:0] sw_in,
    output logic [15:0] led_out,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready
);
    import mem_io_pkg::*;

    localparam int AW = $clog2(RAM_WORDS);

    logic [31:0]   ram_q [RAM_WORDS];
    logic [15:0]   led_q, led_d;
    logic [31:0]   cycle_q, cycle_d;
    logic          misal_q, misal_d, unmap_q, unmap_d;

    logic [3:0]    region;
    logic [5:0]    off;
    size_e         sz;
    logic          uns, is_ram, is_mmio, mmio_hit, access, rd_en, misal, unmapped;
    logic [AW-1:0] widx;
    logic [31:0]   ram_word, lane_word, wdata_rep, status;
    logic [3:0]    be;
    logic          fifo_full, fifo_empty, uart_push, unused_ok;

    assign region   = mem_addr[31:28];
    assign off      = mem_addr[7:2];
    assign sz       = size_e'(mem_u_b_h_w[1:0]);
    assign uns      = mem_u_b_h_w[2];
    assign widx     = mem_addr[AW+1:2];
    assign is_ram   = region == REGION_RAM;
    assign is_mmio  = region == REGION_MMIO;
    assign mmio_hit = is_mmio && (off <= OFF_STATUS);
    assign access   = mem_read | mem_write;
    assign rd_en    = mem_read & ~mem_write;
    // MMIO ignores the size field, so only RAM accesses can be misaligned
    assign misal    = is_ram && is_misaligned(sz, mem_addr[1:0]);
    assign unmapped = !is_ram && !mmio_hit;
    assign uart_push = mem_write && mmio_hit && (off == OFF_UART);

    always_comb begin
        be        = 4'b0000;
        wdata_rep = mem_wdata;
        case (sz)
            SZ_BYTE: begin
                be        = 4'b0001 << mem_addr[1:0];
                wdata_rep = {4{mem_wdata[7:0]}};
            end
            SZ_HALF: begin
                be        = mem_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{mem_wdata[15:0]}};
            end
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (mem_write && is_ram && !misal) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) ram_q[widx][8*b +: 8] <= wdata_rep[8*b +: 8];
        end
    end

    assign ram_word  = ram_q[widx];
    assign lane_word = ram_word >> {mem_addr[1:0], 3'b000};

    always_comb begin
        status           = '0;
        status[ST_FULL]  = fifo_full;
        status[ST_EMPTY] = fifo_empty;
        status[ST_MISAL] = misal_q;
        status[ST_UNMAP] = unmap_q;
    end

    always_comb begin
        mem_rdata = '0;
        if (rd_en && is_ram && !misal) begin
            case (sz)
                SZ_BYTE: mem_rdata = uns ? {24'b0, lane_word[7:0]}
                                         : {{24{lane_word[7]}}, lane_word[7:0]};
                SZ_HALF: mem_rdata = uns ? {16'b0, lane_word[15:0]}
                                         : {{16{lane_word[15]}}, lane_word[15:0]};
                default: mem_rdata = ram_word;
            endcase
        end else if (rd_en && mmio_hit) begin
            case (off)
                OFF_LED:    mem_rdata = {16'b0, led_q};
                OFF_SW:     mem_rdata = {16'b0, sw_in};
                OFF_CYCLE:  mem_rdata = cycle_q;
                OFF_STATUS: mem_rdata = status;
                default:    mem_rdata = '0;
            endcase
        end
    end

    always_comb begin
        led_d   = led_q;
        cycle_d = cycle_q + 32'd1;
        misal_d = misal_q | (access & misal);
        unmap_d = unmap_q | (access & unmapped);
        if (mem_write && mmio_hit) begin
            case (off)
                OFF_LED:   led_d   = mem_wdata[15:0];
                OFF_CYCLE: cycle_d = '0;
                OFF_STATUS: begin
                    if (mem_wdata[ST_MISAL]) misal_d = 1'b0;
                    if (mem_wdata[ST_UNMAP]) unmap_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q   <= '0;
            cycle_q <= '0;
            misal_q <= 1'b0;
            unmap_q <= 1'b0;
        end else begin
            led_q   <= led_d;
            cycle_q <= cycle_d;
            misal_q <= misal_d;
            unmap_q <= unmap_d;
        end
    end

    assign led_out = led_q;

`ifdef MEM_IO_UART_EN
    logic       fifo_pop;
    logic [7:0] fifo_head;

    assign fifo_pop = uart_tx_valid & uart_tx_ready;

    sync_fifo #(.WIDTH(8), .DEPTH(UART_DEPTH)) u_txq (
        .clk     (clk),
        .rst     (rst),
        .push_i  (uart_push),
        .pop_i   (fifo_pop),
        .wdata_i (mem_wdata[7:0]),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign uart_tx_valid = ~fifo_empty;
    assign uart_tx_data  = fifo_head;
    assign unused_ok     = ^mem_addr;
`else
    assign fifo_full     = 1'b0;
    assign fifo_empty    = 1'b1;
    assign uart_tx_valid = 1'b0;
    assign uart_tx_data  = '0;
    assign unused_ok     = ^{mem_addr, uart_push, uart_tx_ready};
`endif

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Randomized bench for mem_io_ctrl against a byte-level behavioural model,
// preceded by hand-computed directed checks.
`timescale 1ns/1ps
module tb_mem_io_ctrl;
    localparam int RAM_WORDS  = 4096;
    localparam int UART_DEPTH = 8;
    localparam int BYTES      = RAM_WORDS * 4;
`ifdef MEM_IO_UART_EN
    localparam bit UART = 1'b1;
`else
    localparam bit UART = 1'b0;
`endif
    localparam logic [31:0] A_LED  = 32'hF000_0000;
    localparam logic [31:0] A_SW   = 32'hF000_0004;
    localparam logic [31:0] A_CYC  = 32'hF000_0008;
    localparam logic [31:0] A_UART = 32'hF000_000C;
    localparam logic [31:0] A_STAT = 32'hF000_0010;

    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] mem_addr = '0, mem_wdata = '0;
    logic [2:0]  mem_u_b_h_w = '0;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [15:0] sw_in = '0;
    logic        uart_tx_ready = 1'b0;
    logic [31:0] mem_rdata;
    logic [15:0] led_out;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;

    mem_io_ctrl #(.RAM_WORDS(RAM_WORDS), .UART_DEPTH(UART_DEPTH)) dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_u_b_h_w(mem_u_b_h_w), .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata), .sw_in(sw_in), .led_out(led_out),
        .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid),
        .uart_tx_ready(uart_tx_ready)
    );

    initial forever #5 clk = ~clk;

    // behavioural model state
    logic [7:0]  mb [BYTES];
    bit          kb [BYTES];
    logic [15:0] m_led = '0;
    logic [31:0] m_cyc = '0;
    bit          m_mis = 0, m_unm = 0;
    logic [7:0]  q [$];
    bit          chk_on = 0;
    bit          rdy_nxt = 0;
    logic [15:0] sw_nxt = '0;
    int          n_cmp = 0, n_err = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic bit mis_model(input logic [31:0] a, input logic [1:0] s);
        return (s == 2'd3) || (s == 2'd1 && a % 2 != 0) || (s == 2'd2 && a % 4 != 0);
    endfunction

    function automatic logic [31:0] exp_status();
        bit full, empty;
        full  = UART && q.size() == UART_DEPTH;
        empty = !UART || q.size() == 0;
        return {28'd0, m_unm, m_mis, empty, full};
    endfunction

    function automatic logic [31:0] exp_rdata(output bit known);
        logic [31:0] a;
        logic [63:0] v;
        int n, base, offs;
        known = 1;
        a = mem_addr;
        if (!mem_read || mem_write) return 32'd0;
        if (a[31:28] == 4'h0) begin
            if (mis_model(a, mem_u_b_h_w[1:0])) return 32'd0;
            n    = (mem_u_b_h_w[1:0] == 2'd0) ? 1 : (mem_u_b_h_w[1:0] == 2'd1) ? 2 : 4;
            base = int'(a % BYTES);
            v    = 0;
            for (int i = 0; i < n; i++) begin
                v = v + (64'(mb[base+i]) << (8*i));
                if (!kb[base+i]) known = 0;
            end
            if (!mem_u_b_h_w[2] && n < 4 && v >= (64'd1 << (8*n-1)))
                v = v + (64'h1_0000_0000 - (64'd1 << (8*n)));
            return v[31:0];
        end
        if (a[31:28] == 4'hF) begin
            offs = int'((a >> 2) % 64);
            case (offs)
                0: return {16'd0, m_led};
                1: return {16'd0, sw_in};
                2: return m_cyc;
                4: return exp_status();
                default: return 32'd0;
            endcase
        end
        return 32'd0;
    endfunction

    task automatic model_step();
        logic [31:0] a, ncyc;
        bit pop, push, room;
        int n, base, offs;
        if (rst) begin
            m_led = '0; m_cyc = '0; m_mis = 0; m_unm = 0; q.delete();
            return;
        end
        a    = mem_addr;
        ncyc = m_cyc + 32'd1;
        push = 0;
        pop  = UART && q.size() > 0 && uart_tx_ready;
        if (mem_read || mem_write) begin
            offs = int'((a >> 2) % 64);
            if (a[31:28] == 4'h0) begin
                if (mis_model(a, mem_u_b_h_w[1:0])) m_mis = 1;
                else if (mem_write) begin
                    n    = (mem_u_b_h_w[1:0] == 2'd0) ? 1 : (mem_u_b_h_w[1:0] == 2'd1) ? 2 : 4;
                    base = int'(a % BYTES);
                    for (int i = 0; i < n; i++) begin
                        mb[base+i] = 8'((mem_wdata >> (8*i)) & 32'hFF);
                        kb[base+i] = 1;
                    end
                end
            end else if (a[31:28] == 4'hF && offs <= 4) begin
                if (mem_write) begin
                    case (offs)
                        0: m_led = mem_wdata[15:0];
                        2: ncyc = 32'd0;
                        3: push = UART;
                        4: begin
                            if (mem_wdata[2]) m_mis = 0;
                            if (mem_wdata[3]) m_unm = 0;
                        end
                        default: ;
                    endcase
                end
            end else m_unm = 1;
        end
        room = q.size() < UART_DEPTH || pop;
        if (pop) void'(q.pop_front());
        if (push && room) q.push_back(mem_wdata[7:0]);
        m_cyc = ncyc;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin : compare
        bit known;
        logic [31:0] e;
        @(negedge clk);
        if (chk_on && !rst) begin
            e = exp_rdata(known);
            if (known) check("rdata", mem_rdata, e);
            check("led_out", {16'd0, led_out}, {16'd0, m_led});
            check("tx_valid", 32'(uart_tx_valid), 32'(UART && q.size() > 0));
            if (UART && q.size() > 0) check("tx_data", {24'd0, uart_tx_data}, {24'd0, q[0]});
            if (!UART) check("tx_data_off", {24'd0, uart_tx_data}, 32'd0);
        end
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s,
                         input bit r, input bit w);
        @(posedge clk); #1;
        mem_addr = a; mem_wdata = d; mem_u_b_h_w = s; mem_read = r; mem_write = w;
        uart_tx_ready = rdy_nxt; sw_in = sw_nxt;
        @(negedge clk);
    endtask

    task automatic idle();
        drive(32'd0, 32'd0, 3'd0, 0, 0);
    endtask

    initial begin : stim
        int k, op;
        logic [31:0] a, d;
        logic [2:0] s;
        bit r, w;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_on = 1;

        drive(A_STAT, 0, 3'b010, 1, 0);
        check("reset_status", mem_rdata, 32'h2);
        check("reset_led", {16'd0, led_out}, 32'd0);
        check("reset_valid", 32'(uart_tx_valid), 32'd0);

        drive(32'h100, 32'h8899AABB, 3'b010, 0, 1);
        drive(32'h103, 0, 3'b000, 1, 0); check("lb_103", mem_rdata, 32'hFFFFFF88);
        drive(32'h102, 0, 3'b100, 1, 0); check("lbu_102", mem_rdata, 32'h00000099);
        drive(32'h100, 0, 3'b001, 1, 0); check("lh_100", mem_rdata, 32'hFFFFAABB);
        drive(32'h101, 32'h5A, 3'b000, 0, 1);
        drive(32'h100, 0, 3'b010, 1, 0); check("sb_merge", mem_rdata, 32'h88995ABB);
        drive(32'h102, 32'h12345678, 3'b010, 0, 1);
        drive(32'h100, 0, 3'b010, 1, 0); check("misal_no_write", mem_rdata, 32'h88995ABB);
        drive(A_STAT, 0, 3'b010, 1, 0); check("status_misal", mem_rdata, 32'h6);
        drive(A_STAT, 32'h4, 3'b010, 0, 1);
        drive(A_STAT, 0, 3'b010, 1, 0); check("status_misal_clr", mem_rdata, 32'h2);
        drive(32'h100, 32'hCAFEF00D, 3'b010, 1, 1); check("rw_both_rdata", mem_rdata, 32'h0);
        drive(32'h100, 0, 3'b010, 1, 0); check("rw_both_write", mem_rdata, 32'hCAFEF00D);
        drive(A_LED, 32'h1234, 3'b010, 0, 1);
        idle(); check("led_write", {16'd0, led_out}, 32'h1234);
        sw_nxt = 16'hBEEF;
        drive(A_SW, 0, 3'b010, 1, 0); check("sw_read", mem_rdata, 32'h0000BEEF);
        drive(A_CYC, 0, 3'b010, 0, 1);
        drive(A_CYC, 0, 3'b010, 1, 0); check("cycle_clr", mem_rdata, 32'd0);
        drive(A_CYC, 0, 3'b010, 1, 0); check("cycle_inc", mem_rdata, 32'd1);
        drive(32'h2000_0000, 0, 3'b010, 1, 0); check("unmapped_rd", mem_rdata, 32'd0);
        drive(A_STAT, 0, 3'b010, 1, 0); check("status_unmap", mem_rdata, 32'hA);
        drive(A_STAT, 32'h8, 3'b010, 0, 1);
        drive(A_STAT, 0, 3'b010, 1, 0); check("status_unmap_clr", mem_rdata, 32'h2);

        if (UART) begin
            for (int i = 1; i <= 9; i++) drive(A_UART, 32'(i), 3'b010, 0, 1);
            drive(A_STAT, 0, 3'b010, 1, 0); check("fifo_full_status", mem_rdata, 32'h1);
            check("fifo_head0", {24'd0, uart_tx_data}, 32'h01);
            rdy_nxt = 1;
            idle(); check("drain_1", {24'd0, uart_tx_data}, 32'h01);
            for (int i = 2; i <= 8; i++) begin
                idle();
                check("drain_valid", 32'(uart_tx_valid), 32'd1);
                check("drain_data", {24'd0, uart_tx_data}, 32'(i));
            end
            idle(); check("drain_done", 32'(uart_tx_valid), 32'd0);
            rdy_nxt = 0;
            for (int i = 0; i < 3; i++) drive(A_UART, 32'h0A + 32'(i), 3'b010, 0, 1);
        end else begin
            drive(A_UART, 32'h55, 3'b010, 0, 1);
            drive(A_STAT, 0, 3'b010, 1, 0); check("uart_off_status", mem_rdata, 32'h2);
            check("uart_off_valid", 32'(uart_tx_valid), 32'd0);
        end
        drive(A_LED, 32'hFFFF, 3'b010, 0, 1);
        idle(); check("pre_rst_led", {16'd0, led_out}, 32'hFFFF);
        check("pre_rst_valid", 32'(uart_tx_valid), 32'(UART));
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        mem_addr = A_STAT; mem_u_b_h_w = 3'b010; mem_read = 1;
        @(negedge clk);
        check("rst_valid", 32'(uart_tx_valid), 32'd0);
        check("rst_led", {16'd0, led_out}, 32'd0);
        check("rst_status", mem_rdata, 32'h2);

        // fill the random-test window so every later load has known data
        for (int i = 0; i < 64; i++) drive(32'(i) << 2, $urandom, 3'b010, 0, 1);

        for (int c = 0; c < 3000; c++) begin
            k = $urandom_range(0, 9);
            d = $urandom; s = 3'($urandom_range(0, 7)); r = 0; w = 0; a = 0;
            rdy_nxt = 1'($urandom_range(0, 1));
            sw_nxt  = 16'($urandom);
            if (k <= 3) begin
                a  = ($urandom & 32'h0FFF_C000) | ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
                op = $urandom_range(0, 3);
                r  = op != 1;
                w  = op == 1 || op == 2;
            end else if (k <= 5) begin
                a = 32'hF000_0000 | ($urandom & 32'h0FFF_FF00) | ($urandom_range(0, 4) << 2);
                s = 3'b010; r = 1;
            end else if (k == 6) begin
                a = 32'hF000_0000 | ($urandom_range(0, 4) << 2);
                s = 3'b010; w = 1;
            end else if (k == 7) begin
                if ($urandom_range(0, 1) == 0)
                    a = ($urandom_range(1, 14) << 28) | ($urandom & 32'h0FFF_FFFC);
                else
                    a = 32'hF000_0000 | ($urandom_range(5, 63) << 2);
                s  = 3'b010;
                op = $urandom_range(0, 2);
                r  = op != 1;
                w  = op != 0;
            end else begin
                a = $urandom;
            end
            drive(a, d, s, r, w);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_io_ctrl.md
# mem_io_ctrl

Memory and I/O controller sitting directly downstream of the load/store unit's memory port. It decodes each access into on-chip data RAM or a small memory-mapped register file and applies byte/half/word lane steering and sign extension. It also owns a free-running cycle counter and a buffered UART transmit queue. Reads are returned combinationally in the same cycle; writes commit on the next rising edge.

## Interface
- RAM_WORDS, 4096: data RAM depth in 32-bit words; power of two.
- UART_DEPTH, 8: transmit FIFO depth in bytes; power of two, at least 2.
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- mem_u_b_h_w  in  3  bit [2] = unsigned load; [1:0]: 00 byte, 01 half, 10 word.
- mem_read  in  1  load strobe.
- mem_write  in  1  store strobe.
- mem_rdata  out  32  extended load result; reset/idle value 0.
- sw_in  in  16  switch inputs.
- led_out  out  16  LED register; reset value 0.
- uart_tx_data  out  8  FIFO head byte.
- uart_tx_valid  out  1  FIFO not empty; reset value 0.
- uart_tx_ready  in  1  consumer accepts the head byte when high with valid.

## Operation
- RAM region: addr[31:28]==4'h0. Word index is addr[2+log2(RAM_WORDS)-1:2]; higher address bits alias.
- MMIO region: addr[31:28]==4'hF, decoded on addr[7:2]. Offsets:
  - 0x00 LED (RW, low 16 bits)
  - 0x04 SW (RO, zero-extended)
  - 0x08 CYCLE (RO; any write clears it to 0)
  - 0x0C UART_DATA (WO; write pushes wdata[7:0])
  - 0x10 STATUS (RO): bit0 fifo full, bit1 fifo empty, bit2 sticky misaligned error, bit3 sticky unmapped error
- Writing STATUS with wdata bit2 or bit3 set clears the corresponding sticky bit.
- Any other address is unmapped: reads return 0, writes are ignored, and both set STATUS bit3.
- Loads:
  - Byte: select lane addr[1:0].
  - Half: select lane addr[1].
  - Word: whole word.
  - Result is zero-extended when bit [2] is 1, otherwise sign-extended.
- Stores: byte enables come from size and addr[1:0]; data is replicated into the selected lane(s). Other bytes are unchanged.
- Misaligned access (half with addr[0]=1, word with addr[1:0]≠0, or size 2'b11) is suppressed: read returns 0, write is dropped, STATUS bit2 is set.
- MMIO registers are accessed as whole words only; the size field is ignored.
- mem_read and mem_write high together: the write wins and mem_rdata returns 0.
- Neither strobe high: mem_rdata is 0.

## Timing
- mem_rdata is combinational from address, size, strobe, RAM contents and registers; there is no wait state.
- RAM and register writes take effect at the rising edge where mem_write=1. A read in the next cycle sees the new data.
- CYCLE increments by 1 every cycle, wrapping from 0xFFFFFFFF to 0. When it is cleared by a write, it reads 0 in the following cycle.
- FIFO:
  - Push occurs on a UART_DATA write. Pop occurs when uart_tx_valid and uart_tx_ready are both high.
  - Push when full is dropped, except when a pop happens in the same cycle; then both occur.
  - Push and pop in the same cycle when not empty leaves the count unchanged.
  - Push when empty: valid rises the next cycle; bytes are never bypassed combinationally.
  - Pointers wrap modulo UART_DEPTH.
- Reset, including mid-operation:
  - Clears LED, CYCLE, FIFO pointers and count, and sticky bits; STATUS reads 0x2.
  - uart_tx_valid is 0 in the cycle after rst is sampled.
  - RAM contents are not reset.

## Configuration
- MEM_IO_UART_EN defined: the FIFO and UART ports are active as described.
- Undefined:
  - The FIFO is not instantiated; UART_DATA writes are ignored without an error.
  - STATUS bit0=0 and bit1=1.
  - uart_tx_valid=0 and uart_tx_data=0 constantly; uart_tx_ready is ignored.

## Structure
- Shared package mem_io_pkg holds:
  - region nibbles and MMIO offsets
  - u_b_h_w size encodings
  - STATUS bit positions
- Sub-module sync_fifo (parameters WIDTH, DEPTH) with push, pop, full, empty and head data. It is instantiated only under MEM_IO_UART_EN.

## Test plan
- Store word 0x8899AABB at 0x100, then lb at 0x103 → 0xFFFFFF88; lbu at 0x102 → 0x00000099; lh at 0x100 → 0xFFFFAABB.
- Store byte 0x5A at 0x101 over 0x8899AABB → word reads 0x88995ABB.
- Word store at 0x102 → RAM unchanged, STATUS bit2=1; STATUS write 0x4 → bit2=0.
- Write LED 0x1234 → led_out=0x1234 next cycle. Write CYCLE → reads 0, then 1 one cycle later.
- With uart_tx_ready=0, push 9 bytes 0x01..0x09 → STATUS=0x1; queue holds 0x01..0x08. Raise ready → bytes 0x01..0x08 drain in order, one per cycle, then valid=0.
- Assert rst with 3 bytes queued and LED=0xFFFF → next cycle uart_tx_valid=0, led_out=0, STATUS=0x2.
